// File: rtl/wb_queue_mp_if.sv
// rtl/wb_queue_mp_if.sv - result-lane and write-port bundle for wb_queue_mp
//
// Purpose: groups the retiring-lane inputs and the register-file write-port
// outputs of the multi-lane writeback queue.
//   i_valid/i_RegWrite/i_MemtoReg/i_PCSrc : per-lane control, lane 0 oldest
//   i_ReadData/i_ALUOut                   : per-lane data, lane k at [k*DW +: DW]
//   i_WA3                                 : per-lane destination, 4 bits per lane
//   o_ready                               : a full N_LANES group can be accepted
//   o_RegWrite/o_WA3/o_Result             : write ports, port 0 oldest
//   o_PCSrc/o_PCResult                    : PC redirect pulse and target
//   o_count/o_overflow                    : occupancy and sticky overflow
// Modports: master drives the lanes (memory stage side), slave is the queue.
interface wb_queue_mp_if #(
  parameter int DW      = 32,
  parameter int N_LANES = 2,
  parameter int N_WP    = 1,
  parameter int DEPTH   = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N_LANES-1:0]    i_valid;
  logic [N_LANES-1:0]    i_RegWrite;
  logic [N_LANES-1:0]    i_MemtoReg;
  logic [N_LANES-1:0]    i_PCSrc;
  logic [N_LANES*DW-1:0] i_ReadData;
  logic [N_LANES*DW-1:0] i_ALUOut;
  logic [N_LANES*4-1:0]  i_WA3;

  logic                  o_ready;
  logic [N_WP-1:0]       o_RegWrite;
  logic [N_WP*4-1:0]     o_WA3;
  logic [N_WP*DW-1:0]    o_Result;
  logic                  o_PCSrc;
  logic [DW-1:0]         o_PCResult;
  logic [CW-1:0]         o_count;
  logic                  o_overflow;

  modport master (
    output i_valid, i_RegWrite, i_MemtoReg, i_PCSrc, i_ReadData, i_ALUOut, i_WA3,
    input  o_ready, o_RegWrite, o_WA3, o_Result, o_PCSrc, o_PCResult, o_count, o_overflow
  );

  modport slave (
    input  i_valid, i_RegWrite, i_MemtoReg, i_PCSrc, i_ReadData, i_ALUOut, i_WA3,
    output o_ready, o_RegWrite, o_WA3, o_Result, o_PCSrc, o_PCResult, o_count, o_overflow
  );
endinterface

// File: rtl/wb_queue_mp.sv
// rtl/wb_queue_mp.sv - multi-lane writeback queue draining to N_WP write ports
//
// Purpose: accepts up to N_LANES retiring results per cycle, selects memory or
// ALU data, compacts useful lanes in order into a circular queue and drains up
// to N_WP oldest entries per cycle to the register file. A PC-redirect entry
// always occupies the last port used in its cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, empties the queue
//   bus  : wb_queue_mp_if.slave (lane inputs, write ports, status)
// Configuration macro: WB_COLLAPSE_EN - when defined, an older same-cycle
// write to the same register as a younger drained write is suppressed.
module wb_queue_mp #(
  parameter int DW      = 32,
  parameter int N_LANES = 2,
  parameter int N_WP    = 1,
  parameter int DEPTH   = 8
) (
  input  logic          clk,
  input  logic          rst,
  wb_queue_mp_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic          regWrite;
    logic          pcSrc;
    logic [3:0]    wa3;
    logic [DW-1:0] result;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ready;

  // Enqueue side
  logic [N_LANES-1:0] useful;
  logic [PW-1:0]      laneOff [N_LANES];
  entry_t             laneEnt [N_LANES];
  logic [CW-1:0]      nEnq;

  // Drain side
  logic [N_WP-1:0] portRw;
  logic [3:0]      portWa  [N_WP];
  logic [DW-1:0]   portRes [N_WP];
  logic            pcOut;
  logic [DW-1:0]   pcRes;
  logic [CW-1:0]   nDrain;
  logic            stop;
  entry_t          cur;

  // Readiness looks only at registered occupancy, so a drain in the same
  // cycle cannot open the door for a group.
  assign ready = (CW'(DEPTH) - count) >= CW'(N_LANES);

  // Running prefix count of useful lanes gives each lane its slot offset
  // from the tail, which compacts the group in lane order.
  always_comb begin
    useful = '0;
    nEnq   = '0;
    for (int k = 0; k < N_LANES; k++) begin
      useful[k]  = bus.i_valid[k] & (bus.i_RegWrite[k] | bus.i_PCSrc[k]);
      laneOff[k] = nEnq[PW-1:0];
      nEnq       = nEnq + {{(CW-1){1'b0}}, useful[k]};
      laneEnt[k] = '{regWrite: bus.i_RegWrite[k],
                     pcSrc:    bus.i_PCSrc[k],
                     wa3:      bus.i_WA3[k*4 +: 4],
                     result:   bus.i_MemtoReg[k] ? bus.i_ReadData[k*DW +: DW]
                                                 : bus.i_ALUOut[k*DW +: DW]};
    end
  end

  // Present the oldest entries in port order; a PC entry ends the cycle's
  // drain so that it is always the last port used.
  always_comb begin
    portRw = '0;
    pcOut  = 1'b0;
    pcRes  = '0;
    nDrain = '0;
    stop   = 1'b0;
    cur    = '0;
    for (int p = 0; p < N_WP; p++) begin
      portWa[p]  = '0;
      portRes[p] = '0;
      cur = mem[head + PW'(p)];
      if (!stop && (CW'(p) < count)) begin
        portRw[p]  = cur.regWrite;
        portWa[p]  = cur.wa3;
        portRes[p] = cur.result;
        nDrain     = nDrain + CW'(1);
        if (cur.pcSrc) begin
          pcOut = 1'b1;
          pcRes = cur.result;
          stop  = 1'b1;
        end
      end
    end
`ifdef WB_COLLAPSE_EN
    // Lower port index is older; drop it when a younger port hits the same
    // register so only the youngest write lands.
    for (int i = 0; i < N_WP; i++) begin
      for (int j = i + 1; j < N_WP; j++) begin
        if (portRw[i] && portRw[j] && (portWa[i] == portWa[j])) begin
          portRw[i] = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      head  <= head + nDrain[PW-1:0];
      count <= count + (ready ? nEnq : '0) - nDrain;
      if (ready) begin
        tail <= tail + nEnq[PW-1:0];
      end else if (|bus.i_valid) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && ready) begin
      for (int k = 0; k < N_LANES; k++) begin
        if (useful[k]) begin
          mem[tail + laneOff[k]] <= laneEnt[k];
        end
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_count    = count;
  assign bus.o_overflow = overflow;
  assign bus.o_PCSrc    = pcOut;
  assign bus.o_PCResult = pcRes;
  assign bus.o_RegWrite = portRw;

  always_comb begin
    bus.o_WA3    = '0;
    bus.o_Result = '0;
    for (int p = 0; p < N_WP; p++) begin
      bus.o_WA3[p*4 +: 4]     = portWa[p];
      bus.o_Result[p*DW +: DW] = portRes[p];
    end
  end
endmodule
